// File: rtl/ysyx_22041752_icache_if.sv
// Fetch-side and refill-memory-side signals of the instruction cache.
// slave = cache side, master = fetch stage / memory side.
interface ysyx_22041752_icache_if #(
    parameter int ADDR_WD = 32,
    parameter int INST_WD = 32
);
    logic               inst_en;
    logic [ADDR_WD-1:0] inst_addr;
    logic [INST_WD-1:0] inst_rdata;
    logic               cache_miss;
    logic               mem_req;
    logic [ADDR_WD-1:0] mem_addr;
    logic               mem_gnt;
    logic               mem_rvalid;
    logic [INST_WD-1:0] mem_rdata;
    logic               mem_rlast;

    modport slave (
        input  inst_en, inst_addr, mem_gnt, mem_rvalid, mem_rdata, mem_rlast,
        output inst_rdata, cache_miss, mem_req, mem_addr
    );

    modport master (
        output inst_en, inst_addr, mem_gnt, mem_rvalid, mem_rdata, mem_rlast,
        input  inst_rdata, cache_miss, mem_req, mem_addr
    );
endinterface

// File: rtl/ysyx_22041752_icache.sv
// Direct-mapped read-only instruction cache with whole-line burst refill.
// Optional hit/miss counters when YSYX_22041752_ICACHE_PERF_EN is defined.
module ysyx_22041752_icache #(
    parameter int ADDR_WD   = 32,
    parameter int INST_WD   = 32,
    parameter int INDEX_WD  = 4,
    parameter int OFFSET_WD = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    ysyx_22041752_icache_if.slave  bus
`ifdef YSYX_22041752_ICACHE_PERF_EN
    ,
    output logic [63:0]            hit_cnt,
    output logic [63:0]            miss_cnt
`endif
);
    localparam int WORD_WD = OFFSET_WD - 2;
    localparam int WORDS   = 1 << WORD_WD;
    localparam int LINES   = 1 << INDEX_WD;
    localparam int TAG_WD  = ADDR_WD - INDEX_WD - OFFSET_WD;

    typedef enum logic [1:0] {IDLE, REQ, DATA, FILL} state_t;

    state_t               state_reg, state_next;
    logic                 req_v_reg;
    logic                 new_req_reg;
    logic [ADDR_WD-1:0]   req_addr_reg;
    logic [WORD_WD-1:0]   beat_cnt_reg;
    logic [INST_WD-1:0]   data_reg [LINES*WORDS];
    logic [LINES-1:0]     line_hit;
    logic                 hit;
    logic                 cache_miss;

    wire [TAG_WD-1:0]   req_tag  = req_addr_reg[ADDR_WD-1 -: TAG_WD];
    wire [INDEX_WD-1:0] req_idx  = req_addr_reg[OFFSET_WD +: INDEX_WD];
    wire [WORD_WD-1:0]  req_word = req_addr_reg[2 +: WORD_WD];
    wire                unused_addr_bits = ^req_addr_reg[1:0];

    // Per-line valid/tag; a fill overwrites whatever occupied the index.
    for (genvar gi = 0; gi < LINES; gi++) begin : g_line
        logic              valid_reg;
        logic [TAG_WD-1:0] tag_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                valid_reg <= 1'b0;
                tag_reg   <= '0;
            end else if (state_reg == FILL && req_idx == INDEX_WD'(gi)) begin
                valid_reg <= 1'b1;
                tag_reg   <= req_tag;
            end
        end

        assign line_hit[gi] = valid_reg && (tag_reg == req_tag) && (req_idx == INDEX_WD'(gi));
    end

    assign hit            = req_v_reg && (|line_hit);
    assign cache_miss     = (req_v_reg && !hit) || (state_reg != IDLE);
    assign bus.cache_miss = cache_miss;
    assign bus.inst_rdata = hit ? data_reg[{req_idx, req_word}] : '0;

    always_ff @(posedge clk) begin
        if (state_reg == DATA && bus.mem_rvalid)
            data_reg[{req_idx, beat_cnt_reg}] <= bus.mem_rdata;
    end

    always_comb begin
        state_next   = state_reg;
        bus.mem_req  = 1'b0;
        bus.mem_addr = '0;
        case (state_reg)
            IDLE: if (req_v_reg && !hit) state_next = REQ;
            REQ: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {req_tag, req_idx, OFFSET_WD'(0)};
                if (bus.mem_gnt) state_next = DATA;
            end
            DATA: if (bus.mem_rvalid && beat_cnt_reg == WORD_WD'(WORDS-1)) state_next = FILL;
            FILL: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            req_v_reg    <= 1'b0;
            new_req_reg  <= 1'b0;
            req_addr_reg <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            // Requests arriving while a miss is outstanding are dropped.
            if (bus.inst_en && !cache_miss) begin
                req_addr_reg <= bus.inst_addr;
                req_v_reg    <= 1'b1;
                new_req_reg  <= 1'b1;
            end else begin
                new_req_reg  <= 1'b0;
            end
            if (state_reg == REQ)
                beat_cnt_reg <= '0;
            else if (state_reg == DATA && bus.mem_rvalid)
                beat_cnt_reg <= beat_cnt_reg + 1'b1;
        end
    end

    // Burst length is fixed by the line size; an early last marker is a memory bug.
    always_ff @(posedge clk) begin
        if (!reset && state_reg == DATA && bus.mem_rvalid && bus.mem_rlast)
            assert (beat_cnt_reg == WORD_WD'(WORDS-1));
    end

`ifdef YSYX_22041752_ICACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (new_req_reg && hit)
                hit_cnt <= hit_cnt + 64'd1;
            if (state_reg == IDLE && state_next == REQ)
                miss_cnt <= miss_cnt + 64'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ysyx_22041752_icache.sv
// Randomized bench for ysyx_22041752_icache against a line-map reference model.
// Checks counters too when YSYX_22041752_ICACHE_PERF_EN is defined.
module tb_ysyx_22041752_icache;
    localparam int WORDS = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ysyx_22041752_icache_if bus ();
`ifdef YSYX_22041752_ICACHE_PERF_EN
    logic [63:0] hit_cnt, miss_cnt;
`endif

    ysyx_22041752_icache dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus)
`ifdef YSYX_22041752_ICACHE_PERF_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: which line address each index currently holds.
    bit          valid_m [16];
    logic [31:0] line_m  [16];
    longint      hits_m   = 0;
    longint      misses_m = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h8000_0000: return 32'h0000_0013;
            32'h8000_0004: return 32'h0010_0093;
            32'h8000_0008: return 32'h0020_0113;
            32'h8000_000C: return 32'h0030_0193;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return valid_m[a[7:4]] && (line_m[a[7:4]] == (a & 32'hFFFF_FFF0));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem_inputs();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rlast  = 1'b0;
        bus.mem_rdata  = $urandom;
    endtask

    // Issue one fetch; on a miss act as the memory with grant delay d and random beat gaps.
    task automatic fetch(input logic [31:0] a, input int d, input int gapmax);
        bit          exp_hit, in_data;
        int          cycles, waited, beat, gap, sumg;
        logic [31:0] line;
        line    = a & 32'hFFFF_FFF0;
        exp_hit = model_hit(a);
        check_eq("ready_before_req", 64'(bus.cache_miss), 64'd0);
        bus.inst_en   = 1'b1;
        bus.inst_addr = a;
        step();
        bus.inst_en   = 1'b0;
        bus.inst_addr = $urandom;
        check_eq("lookup_miss", 64'(bus.cache_miss), 64'(!exp_hit));
        if (exp_hit) begin
            hits_m++;
            check_eq("hit_rdata", 64'(bus.inst_rdata), 64'(mem_word(a)));
            check_eq("hit_no_mem_req", 64'(bus.mem_req), 64'd0);
        end else begin
            misses_m++;
            cycles = 0; waited = 0; beat = 0; sumg = 0; in_data = 1'b0;
            gap = $urandom_range(0, gapmax);
            while (bus.cache_miss && cycles < 400) begin
                cycles++;
                clear_mem_inputs();
                if (!in_data) begin
                    if (bus.mem_req) begin
                        check_eq("mem_addr", 64'(bus.mem_addr), 64'(line));
                        bus.mem_rvalid = 1'($urandom_range(0, 1));
                        if (waited < d) waited++;
                        else begin
                            bus.mem_gnt = 1'b1;
                            in_data     = 1'b1;
                        end
                    end
                end else begin
                    check_eq("mem_req_after_gnt", 64'(bus.mem_req), 64'd0);
                    if (beat < WORDS) begin
                        if (gap > 0) begin
                            gap--;
                            sumg++;
                        end else begin
                            bus.mem_rvalid = 1'b1;
                            bus.mem_rdata  = mem_word(line + 32'(4 * beat));
                            bus.mem_rlast  = (beat == WORDS - 1);
                            beat++;
                            gap = $urandom_range(0, gapmax);
                        end
                    end
                end
                step();
            end
            clear_mem_inputs();
            check_eq("miss_cycles", 64'(cycles), 64'(3 + WORDS + d + sumg));
            valid_m[a[7:4]] = 1'b1;
            line_m[a[7:4]]  = line;
            check_eq("fill_rdata", 64'(bus.inst_rdata), 64'(mem_word(a)));
        end
        $display("[TB] fetch %h exp_hit=%0d rdata=%h", a, exp_hit, bus.inst_rdata);
    endtask

    // Idle cycles: the held request must keep returning the same word.
    task automatic hold(input int n, input logic [31:0] a);
        for (int i = 0; i < n; i++) begin
            bus.inst_addr = $urandom;
            check_eq("hold_rdata", 64'(bus.inst_rdata), 64'(mem_word(a)));
            check_eq("hold_miss", 64'(bus.cache_miss), 64'd0);
            step();
        end
    endtask

    task automatic check_reset_state();
        check_eq("rst_cache_miss", 64'(bus.cache_miss), 64'd0);
        check_eq("rst_mem_req", 64'(bus.mem_req), 64'd0);
        check_eq("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check_eq("rst_inst_rdata", 64'(bus.inst_rdata), 64'd0);
`ifdef YSYX_22041752_ICACHE_PERF_EN
        check_eq("rst_hit_cnt", hit_cnt, 64'd0);
        check_eq("rst_miss_cnt", miss_cnt, 64'd0);
`endif
    endtask

    initial begin
        logic [31:0] a;
        reset         = 1'b1;
        bus.inst_en   = 1'b0;
        bus.inst_addr = '0;
        clear_mem_inputs();
        for (int i = 0; i < 16; i++) valid_m[i] = 1'b0;
        repeat (3) step();
        check_reset_state();
        reset = 1'b0;
        step();

        fetch(32'h8000_0000, 0, 0);
        fetch(32'h8000_000C, 0, 0);
        hold(3, 32'h8000_000C);
        fetch(32'h8000_0100, 0, 0);
        fetch(32'h8000_0000, 0, 0);
        fetch(32'h8000_0040, 5, 3);
        hold(2, 32'h8000_0040);

        for (int i = 0; i < 60; i++) begin
            a = 32'h8000_0000 + (32'($urandom_range(0, 2)) << 8)
                + (32'($urandom_range(0, 15)) << 4) + (32'($urandom_range(0, 3)) << 2);
            fetch(a, $urandom_range(0, 3), $urandom_range(0, 2));
            hold($urandom_range(0, 3), a);
        end

        // Reset in the middle of a refill, after two beats.
        a = 32'h8000_0300;
        bus.inst_en   = 1'b1;
        bus.inst_addr = a;
        step();
        bus.inst_en = 1'b0;
        check_eq("abort_lookup_miss", 64'(bus.cache_miss), 64'd1);
        step();
        check_eq("abort_mem_req", 64'(bus.mem_req), 64'd1);
        bus.mem_gnt = 1'b1;
        step();
        clear_mem_inputs();
        for (int b = 0; b < 2; b++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = mem_word(a + 32'(4 * b));
            step();
        end
        clear_mem_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_state();
        for (int i = 0; i < 16; i++) valid_m[i] = 1'b0;
        hits_m = 0;
        misses_m = 0;
        for (int b = 2; b < 4; b++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = $urandom;
            bus.mem_rlast  = (b == 3);
            step();
            check_eq("post_reset_idle", 64'(bus.cache_miss), 64'd0);
        end
        clear_mem_inputs();
        $display("[TB] reset during refill of %h", a);

        fetch(32'h8000_0000, 0, 0);
        fetch(32'h8000_0004, 0, 0);
        fetch(32'h8000_0008, 0, 0);
        fetch(32'h8000_0100, 1, 1);

`ifdef YSYX_22041752_ICACHE_PERF_EN
        check_eq("hit_cnt", hit_cnt, 64'(hits_m));
        check_eq("miss_cnt", miss_cnt, 64'(misses_m));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_22041752_icache.md
Name: ysyx_22041752_icache

Overview:
Direct-mapped, read-only instruction cache directly upstream of the fetch stage. It services fetch requests issued on inst_en/inst_addr and returns the instruction on inst_rdata one cycle later. When the line is absent it raises cache_miss, which the fetch stage uses as its not-ready condition. On a miss it refills the whole line from a simple burst memory port.

Parameters:
ADDR_WD, 32, fetch and memory address width.
INST_WD, 32, instruction/beat width.
INDEX_WD, 4, line-index bits (2^INDEX_WD lines).
OFFSET_WD, 4, byte-offset bits per line (2^(OFFSET_WD-2) words per line, minimum 3).

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
inst_en  in  1  fetch request strobe, one cycle per request
inst_addr  in  ADDR_WD  fetch byte address, word aligned
inst_rdata  out  INST_WD  instruction for the last accepted request
cache_miss  out  1  high while the last accepted request is not yet served
mem_req  out  1  refill request, held until granted
mem_addr  out  ADDR_WD  line-aligned refill address
mem_gnt  in  1  memory accepts mem_req this cycle
mem_rvalid  in  1  refill beat valid
mem_rdata  in  INST_WD  refill beat data, word 0 first, ascending
mem_rlast  in  1  final beat marker

Behaviour:
- Address split: tag = [ADDR_WD-1:INDEX_WD+OFFSET_WD], index = [INDEX_WD+OFFSET_WD-1:OFFSET_WD], word = [OFFSET_WD-1:2]. Bits [1:0] are ignored.
- Storage: per-line valid bit, tag register and line data registers. Lookup is combinational from the registered request.
- Request capture: when inst_en=1 and cache_miss=0, the block latches inst_addr into req_addr and sets req_v=1. inst_en while cache_miss=1 is illegal; the block ignores it and holds req_addr.
- Latency: a request in cycle N is looked up in cycle N+1. On a hit, cache_miss=0 and inst_rdata = line word in the same cycle (1-cycle hit latency).
- Hold: with no new inst_en, req_addr is held and inst_rdata stays stable on hits for any number of cycles.
- cache_miss = (req_v && !hit) || state!=IDLE. It is combinational and asserted in the first lookup cycle of a miss.
- FSM states:
  - IDLE: on req_v && !hit, go to REQ.
  - REQ: mem_req=1, mem_addr = {req tag, req index, OFFSET_WD'b0}. On mem_gnt, go to DATA with beat_cnt=0.
  - DATA: each mem_rvalid writes mem_rdata into line word beat_cnt, then beat_cnt+1. On the beat where beat_cnt equals the last word, go to FILL.
  - FILL: set valid and tag for the index, go to IDLE. The lookup hits in the following cycle, so cache_miss drops that cycle.
- Miss penalty with mem_gnt and mem_rvalid every cycle: cache_miss is high for 3 + 2^(OFFSET_WD-2) cycles (7 with defaults).
- Completion is decided by beat_cnt. mem_rlast is not required for completion. mem_rlast on any beat other than the last is a protocol error, flagged by a simulation assertion only.
- Mid-refill: mem_rvalid outside DATA is ignored. mem_req stays asserted, with address stable, until mem_gnt.
- Conflict: a refill replaces the line at its index unconditionally.
- Reset values: all valid bits 0, state IDLE, req_v=0, req_addr=0, beat_cnt=0, cache_miss=0, mem_req=0, mem_addr=0, inst_rdata=0.
- Reset during a refill aborts it: the FSM returns to IDLE, no line is marked valid, and memory beats after reset are ignored.
- No write or invalidate path.

Optional Feature:
YSYX_22041752_ICACHE_PERF_EN: when defined, adds output ports hit_cnt[63:0] and miss_cnt[63:0], both reset to 0.
- hit_cnt increments once per request whose first lookup cycle hits.
- miss_cnt increments once per IDLE->REQ transition.
- Held lookup cycles with no new inst_en are not counted.
When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Cold miss at 0x80000000, beats 0x00000013,0x00100093,0x00200113,0x00300193, gnt and rvalid immediate -> mem_addr=0x80000000, cache_miss high 7 cycles, then inst_rdata=0x00000013.
- Then inst_en at 0x8000000C -> next cycle cache_miss=0, inst_rdata=0x00300193, no mem_req.
- Conflict at 0x80000100 (index 0) -> miss, mem_addr=0x80000100; afterwards 0x80000000 misses again.
- mem_gnt delayed 5 cycles and rvalid gapped -> mem_req/mem_addr stable until gnt, correct line installed, cache_miss extends accordingly.
- Reset asserted in DATA after 2 beats -> cache_miss=0, mem_req=0; a later request to 0x80000000 misses again.
- PERF_EN defined: miss, hit, hit, conflict miss -> hit_cnt=2, miss_cnt=2.
